// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection light controller and its monitor:
// lamp codes, tracked phase encodings and default phase lengths.
package traffic_pkg;

    // Car lamp codes driven by the controller
    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_NONE   = 4'b0000;

    // Walker lamp codes driven by the controller
    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_NONE  = 2'b00;

    // Default phase lengths in cycles
    localparam int GREEN_MIN_DEF  = 20;
    localparam int GREEN_MAX_DEF  = 21;
    localparam int YELLOW_LEN_DEF = 2;
    localparam int LEFT_LEN_DEF   = 10;
    localparam int RED_LEN_DEF    = 34;

    localparam logic [6:0] CNT_SAT = 7'd127;

    // Tracked phase, as reported on o_phase
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_GREEN = 3'd1,
        PH_YEL1  = 3'd2,
        PH_LEFT  = 3'd3,
        PH_YEL2  = 3'd4,
        PH_RED   = 3'd5
    } phase_t;

    // Raw phase decoded from the car lamp code alone
    typedef enum logic [2:0] {
        RAW_NONE   = 3'd0,
        RAW_GREEN  = 3'd1,
        RAW_YELLOW = 3'd2,
        RAW_LEFT   = 3'd3,
        RAW_RED    = 3'd4
    } raw_t;

    // The only phase that may follow each phase in a healthy controller
    function automatic phase_t legal_next(input phase_t p);
        case (p)
            PH_IDLE:  return PH_GREEN;
            PH_GREEN: return PH_YEL1;
            PH_YEL1:  return PH_LEFT;
            PH_LEFT:  return PH_YEL2;
            PH_YEL2:  return PH_RED;
            PH_RED:   return PH_GREEN;
            default:  return PH_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_code_decode.sv
// Combinational lamp-code decoder: maps the car code to a raw phase and flags
// any car or walker code the controller should never drive.
module traffic_code_decode
    import traffic_pkg::*;
(
    input  logic [3:0] car_code,
    input  logic [1:0] walker_code,
    output logic [2:0] raw_phase,
    output logic       illegal
);

    // Decode car code to raw phase; anything unlisted or walker 2'b11 is illegal
    always_comb begin
        raw_phase = RAW_NONE;
        illegal   = 1'b0;
        case (car_code)
            CAR_NONE:   raw_phase = RAW_NONE;
            CAR_GREEN:  raw_phase = RAW_GREEN;
            CAR_YELLOW: raw_phase = RAW_YELLOW;
            CAR_LEFT:   raw_phase = RAW_LEFT;
            CAR_RED:    raw_phase = RAW_RED;
            default:    illegal   = 1'b1;
        endcase
        if (walker_code == 2'b11) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/traffic_monitor.sv
// Passive checker beside the light controller: tracks the phase sequence,
// measures phase lengths, counts full cycles and keeps sticky error flags.
module traffic_monitor
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN  = GREEN_MIN_DEF,
    parameter int GREEN_MAX  = GREEN_MAX_DEF,
    parameter int YELLOW_LEN = YELLOW_LEN_DEF,
    parameter int LEFT_LEN   = LEFT_LEN_DEF,
    parameter int RED_LEN    = RED_LEN_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  i_car_traffic,
    input  logic [1:0]  i_walker_traffic,
    input  logic        i_err_clr,
    output logic [2:0]  o_phase,
    output logic [6:0]  o_phase_cnt,
    output logic [15:0] o_cycles,
    output logic        o_err_code,
    output logic        o_err_seq,
    output logic        o_err_len,
    output logic        o_err_conflict
);

    phase_t      state, state_nxt, target;
    logic [6:0]  cnt, cnt_nxt;
    logic [15:0] cycles, cycles_nxt;
    logic        err_code, err_seq, err_len, err_conf;
    logic        err_code_nxt, err_seq_nxt, err_len_nxt, err_conf_nxt;
    logic        set_code, set_seq, set_len, set_conf;
    logic [2:0]  raw_bits;
    raw_t        raw;
    logic        illegal;

    traffic_code_decode u_decode (
        .car_code    (i_car_traffic),
        .walker_code (i_walker_traffic),
        .raw_phase   (raw_bits),
        .illegal     (illegal)
    );

    assign raw = raw_t'(raw_bits);

    // A saturated count is never a legal length, whatever the parameters say
    function automatic logic len_ok(input phase_t p, input logic [6:0] n);
        int lo;
        int hi;
        lo = 0;
        hi = 0;
        case (p)
            PH_GREEN: begin lo = GREEN_MIN;  hi = GREEN_MAX;  end
            PH_YEL1,
            PH_YEL2:  begin lo = YELLOW_LEN; hi = YELLOW_LEN; end
            PH_LEFT:  begin lo = LEFT_LEN;   hi = LEFT_LEN;   end
            PH_RED:   begin lo = RED_LEN;    hi = RED_LEN;    end
            default:  begin lo = 0;          hi = 0;          end
        endcase
        return (n != CNT_SAT) && (int'(n) >= lo) && (int'(n) <= hi);
    endfunction

    // Next-state, count, cycle and flag logic for one sample
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cycles_nxt = cycles;
        target     = state;
        set_code   = 1'b0;
        set_seq    = 1'b0;
        set_len    = 1'b0;
        set_conf   = 1'b0;
        if (illegal) begin
            // Bad code: hold everything and skip the conflict check
            set_code = 1'b1;
        end else begin
            case (raw)
                RAW_NONE:   target = PH_IDLE;
                RAW_GREEN:  target = PH_GREEN;
                RAW_LEFT:   target = PH_LEFT;
                RAW_RED:    target = PH_RED;
                RAW_YELLOW: target = (state == PH_LEFT || state == PH_YEL2) ? PH_YEL2 : PH_YEL1;
                default:    target = PH_IDLE;
            endcase
            if (target == state) begin
                cnt_nxt = (cnt == CNT_SAT) ? cnt : cnt + 7'd1;
            end else begin
                state_nxt = target;
                cnt_nxt   = 7'd1;
                // Dropping to IDLE means the controller stopped: never an error
                if (target != PH_IDLE) begin
                    if (target != legal_next(state)) begin
                        set_seq = 1'b1;
                    end
                    if (state != PH_IDLE && !len_ok(state, cnt)) begin
                        set_len = 1'b1;
                    end
                    if (state == PH_RED && target == PH_GREEN) begin
                        cycles_nxt = cycles + 16'd1;
                    end
                end
            end
            case (raw)
                RAW_GREEN, RAW_YELLOW, RAW_LEFT: set_conf = (i_walker_traffic != WALK_RED);
                RAW_NONE:                        set_conf = (i_walker_traffic != WALK_NONE);
                default:                         set_conf = 1'b0;
            endcase
        end
        // A new error in the clearing cycle survives the clear
        err_code_nxt = (err_code & ~i_err_clr) | set_code;
        err_seq_nxt  = (err_seq  & ~i_err_clr) | set_seq;
        err_len_nxt  = (err_len  & ~i_err_clr) | set_len;
        err_conf_nxt = (err_conf & ~i_err_clr) | set_conf;
    end

    // State, counters and sticky flags; reset discards any partial phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= PH_IDLE;
            cnt      <= 7'd0;
            cycles   <= 16'd0;
            err_code <= 1'b0;
            err_seq  <= 1'b0;
            err_len  <= 1'b0;
            err_conf <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cycles   <= cycles_nxt;
            err_code <= err_code_nxt;
            err_seq  <= err_seq_nxt;
            err_len  <= err_len_nxt;
            err_conf <= err_conf_nxt;
        end
    end

    assign o_phase        = state;
    assign o_phase_cnt    = cnt;
    assign o_cycles       = cycles;
    assign o_err_code     = err_code;
    assign o_err_seq      = err_seq;
    assign o_err_len      = err_len;
    assign o_err_conflict = err_conf;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed bench for traffic_monitor: normal controller periods, bad lengths,
// bad order, walker conflicts, illegal codes and asynchronous reset.
module tb_traffic_monitor;

    logic        clk;
    logic        reset_n;
    logic [3:0]  i_car_traffic;
    logic [1:0]  i_walker_traffic;
    logic        i_err_clr;
    logic [2:0]  o_phase;
    logic [6:0]  o_phase_cnt;
    logic [15:0] o_cycles;
    logic        o_err_code;
    logic        o_err_seq;
    logic        o_err_len;
    logic        o_err_conflict;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] C_RED = 4'b1000, C_YEL = 4'b0100, C_LEFT = 4'b0010,
                           C_GRN = 4'b0001, C_NONE = 4'b0000;
    localparam logic [1:0] W_RED = 2'b10, W_GRN = 2'b01, W_NONE = 2'b00;

    traffic_monitor dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_car_traffic    (i_car_traffic),
        .i_walker_traffic (i_walker_traffic),
        .i_err_clr        (i_err_clr),
        .o_phase          (o_phase),
        .o_phase_cnt      (o_phase_cnt),
        .o_cycles         (o_cycles),
        .o_err_code       (o_err_code),
        .o_err_seq        (o_err_seq),
        .o_err_len        (o_err_len),
        .o_err_conflict   (o_err_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [3:0] car, input logic [1:0] walk, input int n);
        i_car_traffic    = car;
        i_walker_traffic = walk;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        reset_n          = 1'b0;
        i_car_traffic    = C_NONE;
        i_walker_traffic = W_NONE;
        i_err_clr        = 1'b0;
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n          = 1'b0;
        i_car_traffic    = C_NONE;
        i_walker_traffic = W_NONE;
        i_err_clr        = 1'b0;
        #2;
        tests++;
        if ({o_phase, o_phase_cnt, o_cycles, o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 30'd0) begin
            fails++;
            $display("FAIL reset_outputs: got phase=%0d cnt=%0d cyc=%0d flags=%b%b%b%b, want all 0",
                     o_phase, o_phase_cnt, o_cycles, o_err_code, o_err_seq, o_err_len, o_err_conflict);
        end
        tick();
        reset_n = 1'b1;
        run(C_NONE, W_NONE, 2);
        tests++;
        if (o_phase !== 3'd0 || o_phase_cnt !== 7'd2) begin
            fails++;
            $display("FAIL idle_count: got phase=%0d cnt=%0d, want 0/2", o_phase, o_phase_cnt);
        end
    endtask

    task automatic test_normal();
        int g;
        do_reset();
        run(C_NONE, W_NONE, 2);
        for (int p = 0; p < 3; p++) begin
            g = (p == 0) ? 21 : 20;
            run(C_GRN, W_RED, g);
            tests++;
            if (o_phase !== 3'd1 || o_phase_cnt !== 7'(g) || o_cycles !== 16'(p)) begin
                fails++;
                $display("FAIL norm_green p%0d: got phase=%0d cnt=%0d cyc=%0d, want 1/%0d/%0d",
                         p, o_phase, o_phase_cnt, o_cycles, g, p);
            end
            run(C_YEL, W_RED, 2);
            tests++;
            if (o_phase !== 3'd2 || o_phase_cnt !== 7'd2) begin
                fails++;
                $display("FAIL norm_yel1 p%0d: got phase=%0d cnt=%0d, want 2/2", p, o_phase, o_phase_cnt);
            end
            run(C_LEFT, W_RED, 10);
            tests++;
            if (o_phase !== 3'd3 || o_phase_cnt !== 7'd10) begin
                fails++;
                $display("FAIL norm_left p%0d: got phase=%0d cnt=%0d, want 3/10", p, o_phase, o_phase_cnt);
            end
            run(C_YEL, W_RED, 2);
            tests++;
            if (o_phase !== 3'd4 || o_phase_cnt !== 7'd2) begin
                fails++;
                $display("FAIL norm_yel2 p%0d: got phase=%0d cnt=%0d, want 4/2", p, o_phase, o_phase_cnt);
            end
            run(C_RED, W_GRN, 34);
            tests++;
            if (o_phase !== 3'd5 || o_phase_cnt !== 7'd34) begin
                fails++;
                $display("FAIL norm_red p%0d: got phase=%0d cnt=%0d, want 5/34", p, o_phase, o_phase_cnt);
            end
        end
        tests++;
        if (o_cycles !== 16'd2) begin
            fails++;
            $display("FAIL norm_cycles: got %0d want 2", o_cycles);
        end
        tests++;
        if ({o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 4'b0000) begin
            fails++;
            $display("FAIL norm_flags: got %b want 0000", {o_err_code, o_err_seq, o_err_len, o_err_conflict});
        end
    endtask

    task automatic test_long_green();
        do_reset();
        run(C_GRN, W_RED, 25);
        tests++;
        if (o_err_len !== 1'b0 || o_phase_cnt !== 7'd25) begin
            fails++;
            $display("FAIL long_green_before: got len=%b cnt=%0d, want 0/25", o_err_len, o_phase_cnt);
        end
        run(C_YEL, W_RED, 1);
        tests++;
        if (o_err_len !== 1'b1 || o_phase !== 3'd2 || o_err_seq !== 1'b0 || o_phase_cnt !== 7'd1) begin
            fails++;
            $display("FAIL long_green_exit: got len=%b phase=%0d seq=%b cnt=%0d, want 1/2/0/1",
                     o_err_len, o_phase, o_err_seq, o_phase_cnt);
        end
    endtask

    task automatic test_seq_clear();
        do_reset();
        run(C_GRN, W_RED, 21);
        run(C_RED, W_RED, 1);
        tests++;
        if (o_err_seq !== 1'b1 || o_phase !== 3'd5 || o_err_len !== 1'b0) begin
            fails++;
            $display("FAIL seq_green_red: got seq=%b phase=%0d len=%b, want 1/5/0", o_err_seq, o_phase, o_err_len);
        end
        i_err_clr = 1'b1;
        tick();
        i_err_clr = 1'b0;
        tests++;
        if (o_err_seq !== 1'b0 || o_phase !== 3'd5 || o_phase_cnt !== 7'd2) begin
            fails++;
            $display("FAIL seq_clear: got seq=%b phase=%0d cnt=%0d, want 0/5/2", o_err_seq, o_phase, o_phase_cnt);
        end
        // Clear in the same cycle as a new sequence error: the error wins
        i_err_clr = 1'b1;
        run(C_LEFT, W_RED, 1);
        i_err_clr = 1'b0;
        tests++;
        if (o_err_seq !== 1'b1 || o_phase !== 3'd3) begin
            fails++;
            $display("FAIL seq_set_wins: got seq=%b phase=%0d, want 1/3", o_err_seq, o_phase);
        end
    endtask

    task automatic test_conflict();
        do_reset();
        run(C_GRN, W_RED, 21);
        run(C_YEL, W_RED, 2);
        run(C_LEFT, W_GRN, 1);
        tests++;
        if (o_err_conflict !== 1'b1 || o_err_seq !== 1'b0) begin
            fails++;
            $display("FAIL conflict_left_wgreen: got conf=%b seq=%b, want 1/0", o_err_conflict, o_err_seq);
        end
        i_err_clr = 1'b1;
        run(C_LEFT, W_RED, 1);
        i_err_clr = 1'b0;
        tests++;
        if (o_err_conflict !== 1'b0) begin
            fails++;
            $display("FAIL conflict_clear: got %b want 0", o_err_conflict);
        end
        run(C_LEFT, W_RED, 8);
        run(C_YEL, W_RED, 2);
        run(C_RED, W_NONE, 3);
        tests++;
        if ({o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 4'b0000 || o_phase !== 3'd5) begin
            fails++;
            $display("FAIL conflict_red_wnone: got flags=%b phase=%0d, want 0000/5",
                     {o_err_code, o_err_seq, o_err_len, o_err_conflict}, o_phase);
        end
        run(C_NONE, W_RED, 1);
        tests++;
        if (o_err_conflict !== 1'b1 || o_phase !== 3'd0 || o_err_seq !== 1'b0 || o_err_len !== 1'b0) begin
            fails++;
            $display("FAIL conflict_none_wred: got conf=%b phase=%0d seq=%b len=%b, want 1/0/0/0",
                     o_err_conflict, o_phase, o_err_seq, o_err_len);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        run(C_GRN, W_RED, 21);
        run(C_YEL, W_RED, 2);
        run(C_LEFT, W_RED, 4);
        run(4'b0110, W_RED, 3);
        tests++;
        if (o_err_code !== 1'b1 || o_phase !== 3'd3 || o_phase_cnt !== 7'd4) begin
            fails++;
            $display("FAIL illegal_hold: got code=%b phase=%0d cnt=%0d, want 1/3/4", o_err_code, o_phase, o_phase_cnt);
        end
        run(C_LEFT, W_RED, 6);
        tests++;
        if (o_phase_cnt !== 7'd10) begin
            fails++;
            $display("FAIL illegal_resume: got cnt=%0d want 10", o_phase_cnt);
        end
        run(C_YEL, W_RED, 1);
        tests++;
        if (o_err_len !== 1'b0 || o_err_seq !== 1'b0 || o_phase !== 3'd4) begin
            fails++;
            $display("FAIL illegal_left_exit: got len=%b seq=%b phase=%0d, want 0/0/4", o_err_len, o_err_seq, o_phase);
        end
        run(C_RED, 2'b11, 1);
        tests++;
        if (o_phase !== 3'd4 || o_phase_cnt !== 7'd1 || o_err_conflict !== 1'b0) begin
            fails++;
            $display("FAIL illegal_walker: got phase=%0d cnt=%0d conf=%b, want 4/1/0", o_phase, o_phase_cnt, o_err_conflict);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        run(C_GRN, W_RED, 21);
        run(C_YEL, W_RED, 2);
        run(C_LEFT, W_RED, 10);
        run(C_YEL, W_RED, 2);
        run(C_RED, W_GRN, 5);
        run(4'b1111, W_GRN, 1);
        tests++;
        if (o_phase !== 3'd5 || o_phase_cnt !== 7'd5 || o_err_code !== 1'b1) begin
            fails++;
            $display("FAIL areset_setup: got phase=%0d cnt=%0d code=%b, want 5/5/1", o_phase, o_phase_cnt, o_err_code);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests++;
        if ({o_phase, o_phase_cnt, o_cycles, o_err_code, o_err_seq, o_err_len, o_err_conflict} !== 30'd0) begin
            fails++;
            $display("FAIL areset_immediate: got phase=%0d cnt=%0d cyc=%0d flags=%b%b%b%b, want all 0",
                     o_phase, o_phase_cnt, o_cycles, o_err_code, o_err_seq, o_err_len, o_err_conflict);
        end
        #1;
        reset_n = 1'b1;
        run(C_GRN, W_RED, 21);
        run(C_YEL, W_RED, 1);
        tests++;
        if (o_err_seq !== 1'b0 || o_err_len !== 1'b0 || o_phase !== 3'd2) begin
            fails++;
            $display("FAIL areset_resume: got seq=%b len=%b phase=%0d, want 0/0/2", o_err_seq, o_err_len, o_phase);
        end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_long_green();
        test_seq_clear();
        test_conflict();
        test_illegal();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
